// File: rtl/rv32_pkg.sv
// Shared RV32I constants, LSU state encoding and memory-op decode helpers
// used by the MEM-stage load/store unit.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return (opcode == OPC_LOAD) && ok;
  endfunction

  function automatic logic is_store(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return (opcode == OPC_STORE) && ok;
  endfunction

  // Byte accesses can never be misaligned; halfwords need an even address, words a multiple of 4.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = lane[0];
      F3_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte enables and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword out of the returned word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'd0:    byte_s = load_word[7:0];
      2'd1:    byte_s = load_word[15:8];
      2'd2:    byte_s = load_word[23:16];
      2'd3:    byte_s = load_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = load_word[31:16];
    end else begin
      half_s = load_word[15:0];
    end
  end

  // Store steering: replicate the datum across lanes, enables pick the target bytes
  always_comb begin
    wdata = 32'h0000_0000;
    be    = 4'b0000;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << lane;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << lane;
      end
      F3_W: begin
        wdata = store_data;
        be    = 4'b1111;
      end
      default: begin
        wdata = 32'h0000_0000;
        be    = 4'b0000;
      end
    endcase
  end

  // Load extension
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'h00_0000, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'h0000, half_s};
      F3_W:    load_data = load_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues one data-memory request per aligned load/store,
// stalls the front of the pipe until the access completes, and fills MEM/WB.
module mem_stage_lsu
  import rv32_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_EX_MEM,
  input  logic [31:0] ALU_Result_EX_MEM,
  input  logic [31:0] RD2_EX_MEM,
  input  logic [31:0] Instr_EX_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] PC_MEM_WB,
  output logic [31:0] ALU_Result_MEM_WB,
  output logic [31:0] ReadData_MEM_WB,
  output logic [31:0] Instr_MEM_WB,
  output logic        misalign_MEM_WB
);

  lsu_state_e  state_r;
  lsu_state_e  state_next_s;
  logic        live_r;
  logic [2:0]  funct3_s;
  logic [1:0]  lane_s;
  logic        load_s;
  logic        store_s;
  logic        misalign_s;
  logic        mem_op_s;
  logic        capture_s;
  logic [31:0] rdata_r;
  logic [31:0] load_data_s;
  logic [31:0] wdata_s;
  logic [3:0]  be_s;

  assign funct3_s   = Instr_EX_MEM[14:12];
  assign lane_s     = ALU_Result_EX_MEM[1:0];
  assign load_s     = is_load(Instr_EX_MEM[6:0], funct3_s);
  assign store_s    = is_store(Instr_EX_MEM[6:0], funct3_s);
  assign misalign_s = (load_s || store_s) && is_misaligned(funct3_s, lane_s);
  assign mem_op_s   = (load_s || store_s) && !misalign_s;

  lsu_align u_align (
    .funct3     (funct3_s),
    .lane       (lane_s),
    .store_data (RD2_EX_MEM),
    .load_word  (dmem_rdata),
    .wdata      (wdata_s),
    .be         (be_s),
    .load_data  (load_data_s)
  );

  assign dmem_we    = store_s;
  assign dmem_addr  = {ALU_Result_EX_MEM[31:2], 2'b00};
  assign dmem_be    = store_s ? be_s : 4'b0000;
  assign dmem_wdata = wdata_s;

  // State register; live_r keeps the request low for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      live_r  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_REQ: begin
        if (mem_op_s && live_r) begin
          if (!dmem_gnt) begin
            state_next_s = ST_REQ;
          end else if (store_s || dmem_rvalid) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_WAIT_RESP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_RESP: begin
        if (dmem_rvalid) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT_RESP;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: request, pipeline stall and load-data capture strobe
  always_comb begin
    dmem_req  = 1'b0;
    stall_mem = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_REQ: begin
        dmem_req  = mem_op_s && live_r;
        stall_mem = mem_op_s;
        capture_s = mem_op_s && live_r && dmem_gnt && load_s && dmem_rvalid;
      end
      ST_WAIT_RESP: begin
        stall_mem = mem_op_s;
        capture_s = dmem_rvalid;
      end
      ST_DONE: begin
        dmem_req  = 1'b0;
        stall_mem = 1'b0;
        capture_s = 1'b0;
      end
      default: begin
        dmem_req  = 1'b0;
        stall_mem = 1'b0;
        capture_s = 1'b0;
      end
    endcase
  end

  // Holding register for extracted load data; cleared once handed to MEM/WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (capture_s) begin
      rdata_r <= load_data_s;
    end else if (state_r == ST_DONE) begin
      rdata_r <= 32'h0000_0000;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC_MEM_WB         <= 32'h0000_0000;
      ALU_Result_MEM_WB <= 32'h0000_0000;
      ReadData_MEM_WB   <= 32'h0000_0000;
      Instr_MEM_WB      <= 32'h0000_0000;
      misalign_MEM_WB   <= 1'b0;
    end else if (stall_mem) begin
      PC_MEM_WB         <= 32'h0000_0000;
      ALU_Result_MEM_WB <= 32'h0000_0000;
      ReadData_MEM_WB   <= 32'h0000_0000;
      Instr_MEM_WB      <= BUBBLE_INSTR;
      misalign_MEM_WB   <= 1'b0;
    end else begin
      PC_MEM_WB         <= PC_EX_MEM;
      ALU_Result_MEM_WB <= ALU_Result_EX_MEM;
      ReadData_MEM_WB   <= (state_r == ST_DONE) ? rdata_r : 32'h0000_0000;
      Instr_MEM_WB      <= Instr_EX_MEM;
      misalign_MEM_WB   <= misalign_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: hand-computed vectors for pass-through,
// loads/stores with varied grant/response timing, misalignment and reset.
module tb_mem_stage_lsu;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, alu, rd2, instr;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall_mem, misalign_MEM_WB;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] PC_MEM_WB, ALU_Result_MEM_WB, ReadData_MEM_WB, Instr_MEM_WB;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage_lsu #(.BUBBLE_INSTR(BUBBLE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PC_EX_MEM         (pc),
    .ALU_Result_EX_MEM (alu),
    .RD2_EX_MEM        (rd2),
    .Instr_EX_MEM      (instr),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .stall_mem         (stall_mem),
    .PC_MEM_WB         (PC_MEM_WB),
    .ALU_Result_MEM_WB (ALU_Result_MEM_WB),
    .ReadData_MEM_WB   (ReadData_MEM_WB),
    .Instr_MEM_WB      (Instr_MEM_WB),
    .misalign_MEM_WB   (misalign_MEM_WB)
  );

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] i);
    pc = p; alu = a; rd2 = d; instr = i;
  endtask

  logic [31:0] i_add, i_lb, i_lh, i_lw, i_lhu, i_sb, i_sh;

  initial begin
    i_add = mk(7'b0110011, 3'b000);
    i_lb  = mk(7'b0000011, 3'b000);
    i_lh  = mk(7'b0000011, 3'b001);
    i_lw  = mk(7'b0000011, 3'b010);
    i_lhu = mk(7'b0000011, 3'b101);
    i_sb  = mk(7'b0100011, 3'b000);
    i_sh  = mk(7'b0100011, 3'b001);

    rst_n = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = JUNK;
    set_ex(32'h0000_0050, 32'h0000_0004, 32'h0000_0000, i_add);
    step(); step();
    check("rst_instr",    Instr_MEM_WB, 32'h0000_0000);
    check("rst_pc",       PC_MEM_WB, 32'h0000_0000);
    check("rst_rdata",    ReadData_MEM_WB, 32'h0000_0000);
    check("rst_misalign", 32'(misalign_MEM_WB), 32'd0);
    check("rst_req",      32'(dmem_req), 32'd0);
    rst_n = 1'b1;
    step();

    // ADD pass-through
    set_ex(32'h0000_0100, 32'h0000_0010, 32'h0000_0000, i_add);
    #1;
    check("add_stall", 32'(stall_mem), 32'd0);
    check("add_req",   32'(dmem_req), 32'd0);
    step();
    check("add_alu",   ALU_Result_MEM_WB, 32'h0000_0010);
    check("add_pc",    PC_MEM_WB, 32'h0000_0100);
    check("add_instr", Instr_MEM_WB, i_add);
    check("add_rdata", ReadData_MEM_WB, 32'h0000_0000);

    // LB at 0x103, grant and data in the same cycle
    set_ex(32'h0000_0104, 32'h0000_0103, 32'h0000_0000, i_lb);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF12;
    #1;
    check("lb_req",   32'(dmem_req), 32'd1);
    check("lb_we",    32'(dmem_we), 32'd0);
    check("lb_addr",  dmem_addr, 32'h0000_0100);
    check("lb_be",    32'(dmem_be), 32'd0);
    check("lb_stall", 32'(stall_mem), 32'd1);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = JUNK;
    #1;
    check("lb_done_stall", 32'(stall_mem), 32'd0);
    check("lb_done_req",   32'(dmem_req), 32'd0);
    check("lb_bubble",     Instr_MEM_WB, BUBBLE);
    step();
    check("lb_rdata", ReadData_MEM_WB, 32'hFFFF_FF80);
    check("lb_instr", Instr_MEM_WB, i_lb);

    // SH at 0x202, grant arrives on the fourth cycle of the request
    set_ex(32'h0000_0108, 32'h0000_0202, 32'hAAAA_1234, i_sh);
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_gnt = (k == 3);
      #1;
      check("sh_req",   32'(dmem_req), 32'd1);
      check("sh_we",    32'(dmem_we), 32'd1);
      check("sh_be",    32'(dmem_be), 32'hC);
      check("sh_wdata", dmem_wdata, 32'h1234_1234);
      check("sh_addr",  dmem_addr, 32'h0000_0200);
      stall_cnt += int'(stall_mem);
      step();
    end
    dmem_gnt = 1'b0;
    #1;
    check("sh_done_req", 32'(dmem_req), 32'd0);
    stall_cnt += int'(stall_mem);
    check("sh_stall_cycles", 32'(stall_cnt), 32'd4);
    step();
    check("sh_instr", Instr_MEM_WB, i_sh);
    check("sh_alu",   ALU_Result_MEM_WB, 32'h0000_0202);
    check("sh_rdata", ReadData_MEM_WB, 32'h0000_0000);

    // Misaligned LW
    set_ex(32'h0000_010C, 32'h0000_0101, 32'h0000_0000, i_lw);
    #1;
    check("mis_req",   32'(dmem_req), 32'd0);
    check("mis_stall", 32'(stall_mem), 32'd0);
    step();
    check("mis_flag",  32'(misalign_MEM_WB), 32'd1);
    check("mis_rdata", ReadData_MEM_WB, 32'h0000_0000);
    check("mis_instr", Instr_MEM_WB, i_lw);

    // LHU at 0x300, immediate grant, data four cycles later
    set_ex(32'h0000_0110, 32'h0000_0300, 32'h0000_0000, i_lhu);
    dmem_gnt = 1'b1;
    #1;
    check("lhu_req", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check("lhu_wait_req",   32'(dmem_req), 32'd0);
      check("lhu_wait_stall", 32'(stall_mem), 32'd1);
      check("lhu_bubble",     Instr_MEM_WB, BUBBLE);
      step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8001;
    #1;
    check("lhu_rv_stall", 32'(stall_mem), 32'd1);
    step();
    dmem_rvalid = 1'b0; dmem_rdata = JUNK;
    #1;
    check("lhu_done_stall", 32'(stall_mem), 32'd0);
    step();
    check("lhu_rdata",    ReadData_MEM_WB, 32'h0000_8001);
    check("lhu_misalign", 32'(misalign_MEM_WB), 32'd0);

    // SB at lane 1
    set_ex(32'h0000_0114, 32'h0000_0601, 32'h0000_00A5, i_sb);
    dmem_gnt = 1'b1;
    #1;
    check("sb_be",    32'(dmem_be), 32'h2);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    step();
    dmem_gnt = 1'b0;
    step();
    check("sb_instr", Instr_MEM_WB, i_sb);

    // LH at lane 2, sign extension
    set_ex(32'h0000_0118, 32'h0000_0702, 32'h0000_0000, i_lh);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_7777;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = JUNK;
    step();
    check("lh_rdata", ReadData_MEM_WB, 32'hFFFF_8001);

    // Reset while waiting for load data; the late response must be dropped
    set_ex(32'h0000_011C, 32'h0000_0400, 32'h0000_0000, i_lw);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    check("rstw_req",   32'(dmem_req), 32'd0);
    check("rstw_instr", Instr_MEM_WB, 32'h0000_0000);
    check("rstw_rdata", ReadData_MEM_WB, 32'h0000_0000);
    step();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("rstw_idle_req", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = JUNK;
    #1;
    check("rstw_done_stall", 32'(stall_mem), 32'd0);
    step();
    check("rstw_new_rdata", ReadData_MEM_WB, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
